// File: rtl/branch_predictor_2way_pkg.sv
// Shared constants for the 2-way IF-stage branch predictor: datapath width,
// direction-predictor mode codes and 2-bit counter encodings.
package branch_predictor_2way_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    BP_NOT_TAKEN  = 2'd0,
    BP_TAKEN      = 2'd1,
    BP_SATURATING = 2'd2,
    BP_HYSTERESIS = 2'd3
  } bp_mode_e;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_e;

endpackage

// File: rtl/branch_predictor_2way_counter_next.sv
// Next-state function of a 2-bit direction counter for the selected mode.
// Static modes leave the counter untouched.
module bp_counter_next
  import branch_predictor_2way_pkg::*;
(
  input  bp_mode_e   mode,
  input  logic [1:0] counter,
  input  logic       taken,
  output logic [1:0] next_counter
);

  always_comb begin
    next_counter = counter;
    case (mode)
      BP_SATURATING: begin
        if (taken) begin
          if (counter != STRONG_T) next_counter = counter + 2'd1;
        end else begin
          if (counter != STRONG_NT) next_counter = counter - 2'd1;
        end
      end
      BP_HYSTERESIS: begin
        if (taken) begin
          next_counter = (counter == STRONG_NT) ? WEAK_NT : STRONG_T;
        end else begin
          next_counter = (counter == STRONG_T) ? WEAK_T : STRONG_NT;
        end
      end
      default: next_counter = counter;
    endcase
  end

endmodule

// File: rtl/branch_predictor_2way.sv
// 2-way set-associative BTB with per-set LRU, per-entry direction counters
// and saturating resolved/mispredict performance counters.
module branch_predictor_2way
  import branch_predictor_2way_pkg::*;
#(
  parameter int BP_MODE      = 2,
  parameter int BTB_IDX_SIZE = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic                 update_tag,
  input  logic [WORD_SIZE-1:0] pc_for_btb_update,
  input  logic [WORD_SIZE-1:0] branch_target_for_btb_update,
  input  logic                 update_bht,
  input  logic [WORD_SIZE-1:0] pc_for_bht_update,
  input  logic                 branch_taken,
  input  logic                 mispredicted,
  output logic                 tag_match,
  output logic [WORD_SIZE-1:0] branch_predicted_pc,
  output logic [CNT_WIDTH-1:0] resolved_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int SETS  = 1 << BTB_IDX_SIZE;
  localparam int TAG_W = WORD_SIZE - BTB_IDX_SIZE;
  localparam bp_mode_e MODE = bp_mode_e'(BP_MODE[1:0]);
  localparam bit DYNAMIC = (MODE == BP_SATURATING) || (MODE == BP_HYSTERESIS);

  logic                 valid_q  [2][SETS];
  logic [TAG_W-1:0]     tag_q    [2][SETS];
  logic [WORD_SIZE-1:0] target_q [2][SETS];
  logic [1:0]           ctr_q    [2][SETS];
  logic                 lru_q    [SETS];

  // Lookup
  logic [BTB_IDX_SIZE-1:0] l_idx;
  logic [TAG_W-1:0]        l_tag;
  logic                    l_hit0, l_hit1, l_way, l_taken;

  assign l_idx  = pc[BTB_IDX_SIZE-1:0];
  assign l_tag  = pc[WORD_SIZE-1:BTB_IDX_SIZE];
  assign l_hit0 = valid_q[0][l_idx] && (tag_q[0][l_idx] == l_tag);
  assign l_hit1 = valid_q[1][l_idx] && (tag_q[1][l_idx] == l_tag);
  assign l_way  = !l_hit0;
  assign tag_match = l_hit0 || l_hit1;

  always_comb begin
    l_taken = 1'b0;
    case (MODE)
      BP_TAKEN:      l_taken = tag_match;
      BP_SATURATING,
      BP_HYSTERESIS: l_taken = tag_match && ctr_q[l_way][l_idx][1];
      default:       l_taken = 1'b0;
    endcase
  end

  assign branch_predicted_pc = l_taken ? target_q[l_way][l_idx] : pc + WORD_SIZE'(1);

  // BTB install/refresh side
  logic [BTB_IDX_SIZE-1:0] t_idx;
  logic [TAG_W-1:0]        t_tag;
  logic                    t_hit0, t_hit1, t_hit, t_way;

  assign t_idx  = pc_for_btb_update[BTB_IDX_SIZE-1:0];
  assign t_tag  = pc_for_btb_update[WORD_SIZE-1:BTB_IDX_SIZE];
  assign t_hit0 = valid_q[0][t_idx] && (tag_q[0][t_idx] == t_tag);
  assign t_hit1 = valid_q[1][t_idx] && (tag_q[1][t_idx] == t_tag);
  assign t_hit  = t_hit0 || t_hit1;

  always_comb begin
    t_way = lru_q[t_idx];
    if (t_hit0)                  t_way = 1'b0;
    else if (t_hit1)             t_way = 1'b1;
    else if (!valid_q[0][t_idx]) t_way = 1'b0;
    else if (!valid_q[1][t_idx]) t_way = 1'b1;
  end

  // Direction-counter training side
  logic [BTB_IDX_SIZE-1:0] b_idx;
  logic [TAG_W-1:0]        b_tag;
  logic                    b_hit0, b_hit1, b_way, b_en;
  logic [1:0]              b_ctr_next;

  assign b_idx  = pc_for_bht_update[BTB_IDX_SIZE-1:0];
  assign b_tag  = pc_for_bht_update[WORD_SIZE-1:BTB_IDX_SIZE];
  assign b_hit0 = valid_q[0][b_idx] && (tag_q[0][b_idx] == b_tag);
  assign b_hit1 = valid_q[1][b_idx] && (tag_q[1][b_idx] == b_tag);
  assign b_way  = !b_hit0;
  assign b_en   = DYNAMIC && update_bht && (b_hit0 || b_hit1);

  bp_counter_next u_counter_next (
    .mode         (MODE),
    .counter      (ctr_q[b_way][b_idx]),
    .taken        (branch_taken),
    .next_counter (b_ctr_next)
  );

  // The BTB write follows the BHT write so that, on a shared entry, an
  // allocation's counter reset and the BTB-side LRU value take precedence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int unsigned w = 0; w < 2; w++) begin
          valid_q[w][s]  <= 1'b0;
          tag_q[w][s]    <= '0;
          target_q[w][s] <= '0;
          ctr_q[w][s]    <= WEAK_T;
        end
      end
    end else begin
      if (b_en) begin
        ctr_q[b_way][b_idx] <= b_ctr_next;
        lru_q[b_idx]        <= ~b_way;
      end
      if (update_tag) begin
        target_q[t_way][t_idx] <= branch_target_for_btb_update;
        lru_q[t_idx]           <= ~t_way;
        if (!t_hit) begin
          valid_q[t_way][t_idx] <= 1'b1;
          tag_q[t_way][t_idx]   <= t_tag;
          ctr_q[t_way][t_idx]   <= WEAK_T;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resolved_count   <= '0;
      mispredict_count <= '0;
    end else if (update_bht) begin
      if (resolved_count != '1) resolved_count <= resolved_count + CNT_WIDTH'(1);
      if (mispredicted && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_2way.sv
// Drives four predictor instances (one per mode) from shared stimulus and
// compares them against an array-based reference model.
module tb_branch_predictor_2way;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pc = '0;
  logic        update_tag = 1'b0;
  logic [15:0] pc_for_btb_update = '0;
  logic [15:0] branch_target_for_btb_update = '0;
  logic        update_bht = 1'b0;
  logic [15:0] pc_for_bht_update = '0;
  logic        branch_taken = 1'b0;
  logic        mispredicted = 1'b0;

  logic        tm0, tm1, tm2, tm3;
  logic [15:0] pp0, pp1, pp2, pp3;
  logic [15:0] rc0, rc1, rc2, mc0, mc1, mc2;
  logic [3:0]  rc3, mc3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor_2way #(.BP_MODE(0), .BTB_IDX_SIZE(4), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .update_tag(update_tag),
    .pc_for_btb_update(pc_for_btb_update), .branch_target_for_btb_update(branch_target_for_btb_update),
    .update_bht(update_bht), .pc_for_bht_update(pc_for_bht_update), .branch_taken(branch_taken),
    .mispredicted(mispredicted), .tag_match(tm0), .branch_predicted_pc(pp0),
    .resolved_count(rc0), .mispredict_count(mc0));
  branch_predictor_2way #(.BP_MODE(1), .BTB_IDX_SIZE(4), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .update_tag(update_tag),
    .pc_for_btb_update(pc_for_btb_update), .branch_target_for_btb_update(branch_target_for_btb_update),
    .update_bht(update_bht), .pc_for_bht_update(pc_for_bht_update), .branch_taken(branch_taken),
    .mispredicted(mispredicted), .tag_match(tm1), .branch_predicted_pc(pp1),
    .resolved_count(rc1), .mispredict_count(mc1));
  branch_predictor_2way #(.BP_MODE(2), .BTB_IDX_SIZE(4), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .update_tag(update_tag),
    .pc_for_btb_update(pc_for_btb_update), .branch_target_for_btb_update(branch_target_for_btb_update),
    .update_bht(update_bht), .pc_for_bht_update(pc_for_bht_update), .branch_taken(branch_taken),
    .mispredicted(mispredicted), .tag_match(tm2), .branch_predicted_pc(pp2),
    .resolved_count(rc2), .mispredict_count(mc2));
  branch_predictor_2way #(.BP_MODE(3), .BTB_IDX_SIZE(4), .CNT_WIDTH(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .update_tag(update_tag),
    .pc_for_btb_update(pc_for_btb_update), .branch_target_for_btb_update(branch_target_for_btb_update),
    .update_bht(update_bht), .pc_for_bht_update(pc_for_bht_update), .branch_taken(branch_taken),
    .mispredicted(mispredicted), .tag_match(tm3), .branch_predicted_pc(pp3),
    .resolved_count(rc3), .mispredict_count(mc3));

  // Reference model: per instance k (mode k), 16 sets x 2 ways.
  int m_valid [4][16][2];
  int m_tag   [4][16][2];
  int m_tgt   [4][16][2];
  int m_ctr   [4][16][2];
  int m_lru   [4][16];
  int m_res   [4];
  int m_mis   [4];
  int m_max   [4] = '{65535, 65535, 65535, 15};

  function automatic int ref_next(int mode, int c, bit t);
    if (mode == 2) return t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
    if (mode == 3) return t ? ((c == 0) ? 1 : 3) : ((c == 3) ? 2 : 0);
    return c;
  endfunction

  function automatic int find_way(int k, int p);
    for (int w = 0; w < 2; w++)
      if (m_valid[k][p % 16][w] != 0 && m_tag[k][p % 16][w] == p / 16) return w;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_res[k] = 0;
      m_mis[k] = 0;
      for (int s = 0; s < 16; s++) begin
        m_lru[k][s] = 0;
        for (int w = 0; w < 2; w++) begin
          m_valid[k][s][w] = 0; m_tag[k][s][w] = 0; m_tgt[k][s][w] = 0; m_ctr[k][s][w] = 2;
        end
      end
    end
  endtask

  task automatic model_update();
    int pt, pb, ti, bi, th, tw, bh;
    pt = int'(pc_for_btb_update);
    pb = int'(pc_for_bht_update);
    ti = pt % 16;
    bi = pb % 16;
    for (int k = 0; k < 4; k++) begin
      th = find_way(k, pt);
      bh = find_way(k, pb);
      if (th >= 0) tw = th;
      else if (m_valid[k][ti][0] == 0) tw = 0;
      else if (m_valid[k][ti][1] == 0) tw = 1;
      else tw = m_lru[k][ti];
      if (update_bht) begin
        if (m_res[k] < m_max[k]) m_res[k]++;
        if (mispredicted && m_mis[k] < m_max[k]) m_mis[k]++;
        if (k >= 2 && bh >= 0) begin
          m_ctr[k][bi][bh] = ref_next(k, m_ctr[k][bi][bh], branch_taken);
          m_lru[k][bi] = 1 - bh;
        end
      end
      if (update_tag) begin
        m_tgt[k][ti][tw] = int'(branch_target_for_btb_update);
        if (th < 0) begin
          m_valid[k][ti][tw] = 1;
          m_tag[k][ti][tw] = pt / 16;
          m_ctr[k][ti][tw] = 2;
        end
        m_lru[k][ti] = 1 - tw;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_all(string name);
    logic        tm [4];
    logic [15:0] pp [4];
    logic [15:0] rc [4];
    logic [15:0] mc [4];
    int w, p;
    bit taken;
    tm = '{tm0, tm1, tm2, tm3};
    pp = '{pp0, pp1, pp2, pp3};
    rc = '{rc0, rc1, rc2, {12'h000, rc3}};
    mc = '{mc0, mc1, mc2, {12'h000, mc3}};
    p = int'(pc);
    for (int k = 0; k < 4; k++) begin
      w = find_way(k, p);
      taken = (k == 1) ? (w >= 0) : (k >= 2) ? (w >= 0 && m_ctr[k][p % 16][w] >= 2) : 1'b0;
      chk($sformatf("%s tag_match m%0d", name, k), {31'd0, tm[k]}, {31'd0, w >= 0});
      chk($sformatf("%s pred_pc m%0d", name, k), {16'd0, pp[k]},
          taken ? m_tgt[k][p % 16][w] : (p + 1) % 65536);
      chk($sformatf("%s resolved m%0d", name, k), {16'd0, rc[k]}, m_res[k]);
      chk($sformatf("%s mispred m%0d", name, k), {16'd0, mc[k]}, m_mis[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_update();
    #1;
    update_tag = 1'b0;
    update_bht = 1'b0;
    mispredicted = 1'b0;
  endtask

  task automatic look(logic [15:0] p);
    pc = p;
    #1;
  endtask

  task automatic install(logic [15:0] p, logic [15:0] t);
    update_tag = 1'b1; pc_for_btb_update = p; branch_target_for_btb_update = t;
    tick();
  endtask

  task automatic resolve(logic [15:0] p, logic t, logic m);
    update_bht = 1'b1; pc_for_bht_update = p; branch_taken = t; mispredicted = m;
    tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    look(16'h0000);
    chk("rst tm", {31'd0, tm2}, 0);
    chk("rst pred0", {16'd0, pp2}, 16'h0001);
    check_all("rst0");
    look(16'h1234);
    chk("rst pred1234", {16'd0, pp2}, 16'h1235);
    chk("rst rc", {16'd0, rc2}, 0);
    chk("rst mc", {28'd0, mc3}, 0);
    check_all("rst1");

    install(16'h0013, 16'h0040);
    look(16'h0013);
    chk("inst tm", {31'd0, tm2}, 1);
    chk("inst pred", {16'd0, pp2}, 16'h0040);
    check_all("inst");
    resolve(16'h0013, 1'b0, 1'b1);
    resolve(16'h0013, 1'b0, 1'b0);
    look(16'h0013);
    chk("nt2 pred", {16'd0, pp2}, 16'h0014);
    check_all("nt2");
    resolve(16'h0013, 1'b1, 1'b1);
    look(16'h0013);
    chk("t1 pred", {16'd0, pp2}, 16'h0014);
    resolve(16'h0013, 1'b1, 1'b1);
    look(16'h0013);
    chk("t2 pred", {16'd0, pp2}, 16'h0040);
    check_all("t2");

    install(16'h0023, 16'h0050);
    install(16'h0033, 16'h0060);
    look(16'h0013);
    chk("evict tm", {31'd0, tm2}, 0);
    chk("evict pred", {16'd0, pp2}, 16'h0014);
    check_all("evict");
    look(16'h0023);
    chk("keep23 pred", {16'd0, pp2}, 16'h0050);
    check_all("keep23");
    look(16'h0033);
    chk("new33 pred", {16'd0, pp2}, 16'h0060);
    check_all("new33");

    install(16'h0057, 16'h0070);
    resolve(16'h0057, 1'b0, 1'b0);
    resolve(16'h0057, 1'b1, 1'b1);
    look(16'h0057);
    chk("hyst 01 pred", {16'd0, pp3}, 16'h0058);
    resolve(16'h0057, 1'b1, 1'b1);
    look(16'h0057);
    chk("hyst 11 pred", {16'd0, pp3}, 16'h0070);
    check_all("hyst");

    update_tag = 1'b1; pc_for_btb_update = 16'h0045; branch_target_for_btb_update = 16'h0090;
    update_bht = 1'b1; pc_for_bht_update = 16'h0045; branch_taken = 1'b0;
    tick();
    look(16'h0045);
    chk("same m2 pred", {16'd0, pp2}, 16'h0090);
    chk("same m3 pred", {16'd0, pp3}, 16'h0090);
    check_all("same");
    look(16'hFFFF);
    chk("wrap pred", {16'd0, pp2}, 16'h0000);
    check_all("wrap");

    for (int i = 0; i < 20; i++) resolve(16'h0AA5, 1'b0, 1'b1);
    look(16'h0023);
    chk("sat rc", {28'd0, rc3}, 4'hF);
    chk("sat mc", {28'd0, mc3}, 4'hF);
    check_all("sat");

    @(negedge clk);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async rc", {28'd0, rc3}, 0);
    chk("async mc2", {16'd0, mc2}, 0);
    chk("async tm", {31'd0, tm2}, 0);
    check_all("async");
    update_tag = 1'b1; pc_for_btb_update = 16'h0023; branch_target_for_btb_update = 16'h0077;
    tick();
    look(16'h0023);
    chk("rst ignore", {31'd0, tm2}, 0);
    #3 reset_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [15:0] pt;
      pt = {12'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 15) == 0) pt = 16'($urandom);
      update_tag = 1'($urandom);
      pc_for_btb_update = pt;
      branch_target_for_btb_update = 16'($urandom);
      update_bht = 1'($urandom);
      pc_for_bht_update = ($urandom_range(0, 3) == 0) ? pt
                        : {12'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      branch_taken = 1'($urandom);
      mispredicted = 1'($urandom);
      tick();
      look({12'($urandom_range(0, 4)), 4'($urandom_range(0, 15))});
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_2way.md
# branch_predictor_2way

Parametrised successor to the single-way IF-stage branch predictor. It combines a 2-way set-associative BTB with per-set LRU replacement, per-entry valid bits and a mode-selectable direction predictor (static or 2-bit dynamic). Lookup is combinational on the IF PC. BTB and BHT state is written at ID/EX, and saturating performance counters expose prediction accuracy.

## Interface
- BP_MODE, 2: direction scheme. 0 always-not-taken, 1 always-taken, 2 2-bit saturating, 3 2-bit hysteresis.
- BTB_IDX_SIZE, 4: log2 of set count. Tag width is WORD_SIZE-BTB_IDX_SIZE.
- CNT_WIDTH, 16: width of each performance counter.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc  in  WORD_SIZE  IF PC being looked up.
- update_tag  in  1  ID: install or refresh a BTB entry.
- pc_for_btb_update  in  WORD_SIZE  branch/jump PC to install.
- branch_target_for_btb_update  in  WORD_SIZE  its target.
- update_bht  in  1  ID/EX: resolved outcome is valid.
- pc_for_bht_update  in  WORD_SIZE  resolved branch PC.
- branch_taken  in  1  actual direction.
- mispredicted  in  1  pipeline flushed for this branch; sampled with update_bht.
- tag_match  out  1  valid hit in either way of pc's set.
- branch_predicted_pc  out  WORD_SIZE  next fetch PC.
- resolved_count  out  CNT_WIDTH  number of update_bht pulses.
- mispredict_count  out  CNT_WIDTH  number of update_bht&&mispredicted pulses.

## Operation
- pc splits as {tag, idx}. Hit = valid && tag equal, per way. At most one way hits; if both hit, way 0 wins.
- Predict taken: mode 0 never; mode 1 on hit; modes 2/3 on hit && counter[1].
- branch_predicted_pc = taken ? target of the hit way : pc+1. The addition wraps modulo 2^WORD_SIZE.
- update_tag, entry already present (hit in set): overwrite its target. Counter is unchanged. LRU bit is set to the other way.
- update_tag, entry absent: the victim is the first invalid way (way 0 before way 1), otherwise the way named by the LRU bit. The victim receives valid=1, new tag and target, counter 2'b10. LRU bit is set to the other way.
- update_bht on a hit, modes 2/3: counter updated and LRU bit set to the other way. On a miss, or in modes 0/1, no BTB/BHT change.
- Saturating mode (2):
  - taken: +1, saturating at 2'b11.
  - not taken: -1, saturating at 2'b00.
- Hysteresis mode (3):
  - taken: 00→01, 01→11, 10→11, 11→11.
  - not taken: 11→10, 10→00, 01→00, 00→00.
- Performance counters increment in all modes, regardless of hit, and saturate at all-ones (no wrap).
- Simultaneous update_tag and update_bht to the same entry:
  - If update_tag allocates that entry, the counter reset to 10 wins.
  - If update_tag refreshes that entry, the target is written and the counter takes the update_bht value.
  - The LRU value from update_tag wins.
- Simultaneous updates to different sets are independent.

## Timing
- Lookup is purely combinational from registered state. There is no write-to-read bypass: an update at edge N is visible to lookups from cycle N+1 onward.
- All writes occur on the rising edge of clk.
- Reset (asynchronous assert, effective immediately, including mid-operation):
  - all valid bits 0, counters 2'b10, targets 0, LRU bits 0, performance counters 0.
  - Hence tag_match=0 and branch_predicted_pc=pc+1.
- Update inputs are ignored while reset_n=0. Deassertion is synchronised externally.

## Structure
- constants.v gains:
  - BP_MODE codes: BP_NOT_TAKEN, BP_TAKEN, BP_SATURATING, BP_HYSTERESIS.
  - Counter encodings: STRONG_NT 00, WEAK_NT 01, WEAK_T 10, STRONG_T 11.
- WORD_SIZE comes from the existing constants.
- One sub-module, bp_counter_next: combinational (mode, counter, taken) → next counter. It is reused by any future tournament predictor.
- Storage is kept as flat register arrays per way: valid, tag, target, counter. LRU is one bit per set.

## Test plan
- Reset, then lookup pc=16'h0000 and 16'h1234 → tag_match=0, predicted 16'h0001 / 16'h1235; both counters read 0.
- Mode 2: update_tag pc=16'h0013, target 16'h0040 → next cycle pc=16'h0013 gives tag_match=1, predicted 16'h0040. Two not-taken updates → predicted 16'h0014. One taken update still gives 16'h0014; a second gives 16'h0040.
- Set conflict, idx 3: install 16'h0013, 16'h0023, then 16'h0033 → 16'h0013 is evicted (miss, predicted 16'h0014), 16'h0023 and 16'h0033 hit.
- Mode 3: from 10, not-taken → 00; taken → 01 (predict pc+1); taken → 11 (predict target).
- Same-cycle update_tag allocation and update_bht not-taken on 16'h0045 → counter is 10 and the entry predicts taken next cycle. pc=16'hFFFF on a miss → predicted 16'h0000.
- CNT_WIDTH=4: 20 update_bht pulses with mispredicted=1 → both counters hold 4'hF. Assert reset_n low mid-stream → counters 0 and tag_match=0 immediately, without a clock edge.
